// File: rtl/key_loader.sv
// -----------------------------------------------------------------------------
// key_loader
//   Upstream feeder for the key word store. Accepts a narrow valid/ready key
//   stream, packs IN_WIDTH-bit beats (first beat = LSBs) into WORD_SIZE-bit
//   words and issues indexed word writes. key_valid is raised once all WORDS
//   words have been written. A zeroize pulse overwrites every stored word
//   with 0. Priority each cycle: zeroize > start > stream activity.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   start      pulse: begin (or restart) a key load
//   zeroize    pulse: clear all stored words to 0
//   in_valid   stream beat valid
//   in_data    stream beat (IN_WIDTH bits)
//   in_ready   beat accepted when in_valid & in_ready
//   widx       word index to store
//   wen        one-cycle word write strobe
//   wdata      word to store
//   key_valid  full key present in store
//   busy       high while loading or zeroizing
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module key_loader #(
  parameter int WORDS     = 4,
  parameter int WORD_SIZE = 32,
  parameter int IN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       zeroize,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       in_ready,
  output logic [$clog2(WORDS)-1:0]   widx,
  output logic                       wen,
  output logic [WORD_SIZE-1:0]       wdata,
  output logic                       key_valid,
  output logic                       busy
);

  localparam int BEATS = WORD_SIZE / IN_WIDTH;
  localparam int IW    = $clog2(WORDS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ZW    = IW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [BW-1:0]        beat_idx, beat_idx_n;
  logic [IW-1:0]        word_idx, word_idx_n;
  logic [WORD_SIZE-1:0] pack, pack_n;
  logic [ZW-1:0]        zcnt, zcnt_n;
  // Last word has been written; key_valid follows one cycle after its wen.
  logic                 fin, fin_n;

  logic                 in_ready_n;
  logic [IW-1:0]        widx_n;
  logic                 wen_n;
  logic [WORD_SIZE-1:0] wdata_n;
  logic                 key_valid_n;
  logic                 busy_n;

  logic                 accept;
  logic [WORD_SIZE-1:0] word_asm;

  // Drop beat k into its slot of the word being assembled.
  function automatic logic [WORD_SIZE-1:0] insert_beat(
    input logic [WORD_SIZE-1:0] word,
    input logic [BW-1:0]        k,
    input logic [IN_WIDTH-1:0]  beat
  );
    logic [WORD_SIZE-1:0] w;
    w = word;
    w[k*IN_WIDTH +: IN_WIDTH] = beat;
    return w;
  endfunction

  always_comb begin
    state_n     = state;
    beat_idx_n  = beat_idx;
    word_idx_n  = word_idx;
    pack_n      = pack;
    zcnt_n      = zcnt;
    fin_n       = fin;
    in_ready_n  = in_ready;
    widx_n      = widx;
    wen_n       = 1'b0;
    wdata_n     = wdata;
    key_valid_n = key_valid;
    busy_n      = busy;

    accept   = in_valid && in_ready;
    word_asm = insert_beat(pack, beat_idx, in_data);

    if (zeroize) begin
      // First clearing write goes out right away; a beat accepted now is lost.
      state_n     = ZERO;
      zcnt_n      = ZW'(1);
      wen_n       = 1'b1;
      widx_n      = '0;
      wdata_n     = '0;
      in_ready_n  = 1'b0;
      key_valid_n = 1'b0;
      busy_n      = 1'b1;
      fin_n       = 1'b0;
      beat_idx_n  = '0;
      word_idx_n  = '0;
      pack_n      = '0;
    end else if (start && state != ZERO) begin
      // (Re)start: any partial word is discarded, stored words stay until overwritten.
      state_n     = LOAD;
      in_ready_n  = 1'b1;
      key_valid_n = 1'b0;
      busy_n      = 1'b1;
      fin_n       = 1'b0;
      beat_idx_n  = '0;
      word_idx_n  = '0;
      pack_n      = '0;
    end else begin
      case (state)
        LOAD: begin
          if (fin) begin
            state_n     = DONE;
            key_valid_n = 1'b1;
            busy_n      = 1'b0;
            fin_n       = 1'b0;
          end else if (accept) begin
            pack_n = word_asm;
            if (beat_idx == BW'(BEATS - 1)) begin
              wen_n      = 1'b1;
              widx_n     = word_idx;
              wdata_n    = word_asm;
              beat_idx_n = '0;
              if (word_idx == IW'(WORDS - 1)) begin
                fin_n      = 1'b1;
                in_ready_n = 1'b0;
              end else begin
                word_idx_n = word_idx + IW'(1);
              end
            end else begin
              beat_idx_n = beat_idx + BW'(1);
            end
          end
        end
        ZERO: begin
          if (zcnt == ZW'(WORDS)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            wen_n   = 1'b1;
            widx_n  = zcnt[IW-1:0];
            wdata_n = '0;
            zcnt_n  = zcnt + ZW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_idx  <= '0;
      word_idx  <= '0;
      pack      <= '0;
      zcnt      <= '0;
      fin       <= 1'b0;
      in_ready  <= 1'b0;
      widx      <= '0;
      wen       <= 1'b0;
      wdata     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      beat_idx  <= beat_idx_n;
      word_idx  <= word_idx_n;
      pack      <= pack_n;
      zcnt      <= zcnt_n;
      fin       <= fin_n;
      in_ready  <= in_ready_n;
      widx      <= widx_n;
      wen       <= wen_n;
      wdata     <= wdata_n;
      key_valid <= key_valid_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// -----------------------------------------------------------------------------
// tb_key_loader
//   Self-checking bench for key_loader (WORDS=4, WORD_SIZE=32, IN_WIDTH=8).
//   Expected word writes are queued as stimulus is driven and popped by a
//   monitor whenever the DUT strobes wen. Full loads come from a table;
//   restart, zeroize, start+zeroize and async reset are hand-written.
// -----------------------------------------------------------------------------
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [1:0]  widx;
  logic        wen;
  logic [31:0] wdata;
  logic        key_valid;
  logic        busy;

  key_loader #(.WORDS(4), .WORD_SIZE(32), .IN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .zeroize(zeroize),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .widx(widx), .wen(wen), .wdata(wdata), .key_valid(key_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    bit          toggle;
    logic [31:0] exp_w [4];
  } vec_t;

  wr_t exp_q [$];
  wr_t mon_e;
  int  compared = 0;
  int  mismatched = 0;
  int  wen_cnt = 0;
  int  cyc = 0;
  int  last_wen_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every observed write must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && wen) begin
      wen_cnt++;
      last_wen_cyc = cyc;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_wen: widx=%0d wdata=0x%0h, no write expected", widx, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wen_widx", 64'(widx), 64'(mon_e.idx));
        check("wen_wdata", 64'(wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic push_word(input logic [1:0] idx, input logic [31:0] data);
    wr_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Expected words for consecutive bytes starting at base.
  task automatic push_load(input logic [7:0] base, input int nwords);
    logic [7:0] b;
    for (int w = 0; w < nwords; w++) begin
      b = base + 8'(4 * w);
      push_word(2'(w), {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
  endtask

  task automatic push_zero();
    for (int w = 0; w < 4; w++) push_word(2'(w), 32'h0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drive n beats base, base+1, ...; returns 1 time unit after the last accept.
  task automatic feed(input logic [7:0] base, input int n, input bit toggle);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      t   = 0;
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) check("feed_timeout", 64'(acc), 64'(1));
      if (toggle) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_key(input string name);
    int t;
    t = 0;
    while (!key_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({name, "_key_valid"}, 64'(key_valid), 64'(1));
    check({name, "_kv_latency"}, 64'(cyc - last_wen_cyc), 64'(1));
    check({name, "_in_ready"}, 64'(in_ready), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'(0));
    check({name, "_wen"}, 64'(wen), 64'(0));
    check({name, "_widx"}, 64'(widx), 64'(0));
    check({name, "_wdata"}, 64'(wdata), 64'(0));
    check({name, "_key_valid"}, 64'(key_valid), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  vec_t vecs [3];

  initial begin
    vecs[0].base = 8'h00; vecs[0].toggle = 1'b0;
    vecs[0].exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    vecs[1].base = 8'h00; vecs[1].toggle = 1'b1;
    vecs[1].exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    vecs[2].base = 8'hF0; vecs[2].toggle = 1'b0;
    vecs[2].exp_w = '{32'hF3F2F1F0, 32'hF7F6F5F4, 32'hFBFAF9F8, 32'hFFFEFDFC};

    // Reset state
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("post_reset_idle");

    // Full loads from the table (back-to-back, toggled valid, from DONE)
    for (int v = 0; v < 3; v++) begin
      wen_cnt = 0;
      pulse_start();
      check("load_start_kv_clear", 64'(key_valid), 64'(0));
      check("load_start_ready", 64'(in_ready), 64'(1));
      check("load_start_busy", 64'(busy), 64'(1));
      for (int w = 0; w < 4; w++) push_word(2'(w), vecs[v].exp_w[w]);
      feed(vecs[v].base, 16, vecs[v].toggle);
      wait_key("load");
      check("load_wen_count", 64'(wen_cnt), 64'(4));
      check("load_queue_empty", 64'(exp_q.size()), 64'(0));
    end

    // Zeroize from DONE
    wen_cnt = 0;
    push_zero();
    @(posedge clk); #1 zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    check("zero_kv", 64'(key_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_busy", 64'(busy), 64'(1));
      check("zero_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    check("zero_end_busy", 64'(busy), 64'(0));
    check("zero_end_wen", 64'(wen), 64'(0));
    check("zero_wen_count", 64'(wen_cnt), 64'(4));

    // start and zeroize together in IDLE: zeroize wins, no load
    wen_cnt = 0;
    push_zero();
    @(posedge clk); #1 start = 1'b1; zeroize = 1'b1;
    @(posedge clk); #1 start = 1'b0; zeroize = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("sz_ready", 64'(in_ready), 64'(0));
    end
    check("sz_wen_count", 64'(wen_cnt), 64'(4));
    check("sz_busy", 64'(busy), 64'(0));

    // Restart mid-load: 6 beats, start again, 16 beats
    wen_cnt = 0;
    pulse_start();
    push_word(2'd0, 32'h03020100);
    feed(8'h00, 6, 1'b0);
    pulse_start();
    check("restart_kv", 64'(key_valid), 64'(0));
    push_load(8'h10, 4);
    feed(8'h10, 16, 1'b0);
    wait_key("restart");
    check("restart_wen_count", 64'(wen_cnt), 64'(5));

    // Asynchronous reset after 10 beats
    wen_cnt = 0;
    pulse_start();
    push_load(8'h20, 2);
    feed(8'h20, 10, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    check("async_rst_wen_count", 64'(wen_cnt), 64'(2));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("async_rst_release");
    wen_cnt = 0;
    pulse_start();
    push_load(8'h40, 4);
    feed(8'h40, 16, 1'b0);
    wait_key("after_rst");
    check("after_rst_wen_count", 64'(wen_cnt), 64'(4));

    repeat (3) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
